// File: rtl/muldiv_sched_if.sv
// muldiv_sched_if
//   E-stage request and D-stage hazard bundle for the HI/LO multiply/divide
//   sequencer.
//   master : E/D-stage side. Drives start, op, A, B, lock and hilo_use_D.
//            Observes busy, stall, HIO and LOO.
//   slave  : the sequencer. Sees the requests and drives the status and
//            HI/LO outputs.
interface muldiv_sched_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        lock;
    logic        hilo_use_D;
    logic        busy;
    logic        stall;
    logic [31:0] HIO;
    logic [31:0] LOO;

    modport master (
        output start, op, A, B, lock, hilo_use_D,
        input  busy, stall, HIO, LOO
    );

    modport slave (
        input  start, op, A, B, lock, hilo_use_D,
        output busy, stall, HIO, LOO
    );
endinterface

// File: rtl/muldiv_sched.sv
// muldiv_sched
//   Multi-cycle multiply/divide sequencer in the E stage. It owns the
//   architectural HI/LO registers.
//   - A mult/div result is computed at the accepting edge and held in hi_n/lo_n.
//   - HI/LO are written only when the busy count expires.
//   - mthi/mtlo write HI/LO directly.
//   Ports:
//     clk   rising-edge clock
//     rst_n asynchronous active-low reset
//     bus   muldiv_sched_if.slave, which carries the following signals:
//           start, op, A, B  : E-stage HI/LO operation request
//           lock             : E-stage flush; the new request is dropped
//           hilo_use_D       : D-stage instruction touches HI/LO
//           busy, stall      : sequencer status and D-stage hold
//           HIO, LOO         : committed HI/LO
module muldiv_sched #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    muldiv_sched_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] hi, lo, hi_n, lo_n;

    logic        busy_i, accept, is_md;
    logic [63:0] prod_s, prod_u;
    logic        div_zero, div_ovf;
    logic [31:0] div_bs, div_bu;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic [31:0] res_hi, res_lo;

    // RUN is held exactly while cnt != 0.
    assign busy_i = (state == RUN);
    // The reset term keeps stall low while rst_n is asserted.
    assign accept = rst_n & bus.start & ~bus.lock & ~busy_i;
    assign is_md  = ~bus.op[2];

    assign bus.busy  = busy_i;
    assign bus.stall = bus.hilo_use_D & (busy_i | (accept & is_md));
    assign bus.HIO   = hi;
    assign bus.LOO   = lo;

    assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
    assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

    // The special cases are muxed in below. Here the divisor is replaced by 1
    // so the dividers never see /0 or signed overflow.
    assign div_zero = (bus.B == '0);
    assign div_ovf  = (bus.A == 32'h8000_0000) & (bus.B == '1);
    assign div_bs   = (div_zero | div_ovf) ? 32'd1 : bus.B;
    assign div_bu   = div_zero ? 32'd1 : bus.B;
    assign q_s      = $signed(bus.A) / $signed(div_bs);
    assign r_s      = $signed(bus.A) % $signed(div_bs);
    assign q_u      = bus.A / div_bu;
    assign r_u      = bus.A % div_bu;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        case (bus.op)
            3'b000: {res_hi, res_lo} = prod_s;
            3'b001: {res_hi, res_lo} = prod_u;
            3'b010: begin
                if (div_zero) begin
                    res_hi = bus.A;
                    res_lo = '1;
                end else if (div_ovf) begin
                    res_hi = '0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            3'b011: begin
                if (div_zero) begin
                    res_hi = bus.A;
                    res_lo = '1;
                end else begin
                    res_hi = r_u;
                    res_lo = q_u;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            hi_n  <= '0;
            lo_n  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (bus.op)
                            3'b000, 3'b001: begin
                                hi_n  <= res_hi;
                                lo_n  <= res_lo;
                                cnt   <= MULT_LOAD;
                                state <= RUN;
                            end
                            3'b010, 3'b011: begin
                                hi_n  <= res_hi;
                                lo_n  <= res_lo;
                                cnt   <= DIV_LOAD;
                                state <= RUN;
                            end
                            3'b100: hi <= bus.A;
                            3'b101: lo <= bus.A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    // Lock is ignored here. The op in flight belongs to a
                    // committed instruction.
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        hi    <= hi_n;
                        lo    <= lo_n;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/muldiv_sched.md
# muldiv_sched

Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline with exceptions and interrupts. It sits in the E stage and owns the HI/LO registers that feed the HIO/LOO inputs of the E-stage result mux. It accepts mult/multu/div/divu/mthi/mtlo from E and holds HI/LO for a fixed latency per operation. It raises a D-stage stall while HI/LO is in use, and drops any new operation in the cycle the exception/interrupt lock is asserted.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (1..15)

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  E-stage instruction is a HI/LO operation
- op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, others no-op
- A  in  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- B  in  32  rt operand (divisor / multiplier)
- lock  in  1  lock_muldiv (ExcReq | IntReq); E-stage instruction is being flushed
- hilo_use_D  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  operation in flight
- stall  out  1  hold D stage (and the stages before it)
- HIO  out  32  architectural HI
- LOO  out  32  architectural LO

## Operation
- accept = start & ~lock & ~busy. If start & busy, the request is ignored; the stall logic prevents this case in normal operation.
- mult/multu accepted: compute the 64-bit product at the accepting edge (signed or unsigned). Latch {hi_n, lo_n} and load cnt = MULT_CYCLES.
- div/divu accepted: compute quotient to lo_n and remainder to hi_n (signed or unsigned). Load cnt = DIV_CYCLES.
  - Signed remainder takes the sign of the dividend.
  - B == 0: lo_n = 32'hFFFF_FFFF, hi_n = A (both signed and unsigned).
  - Signed A = 32'h8000_0000, B = 32'hFFFF_FFFF: lo_n = 32'h8000_0000, hi_n = 0.
- mthi/mtlo accepted: HI (or LO) = A at that edge. No busy, cnt unchanged.
- Undefined op with start: no effect.
- FSM: IDLE (cnt == 0) and RUN (cnt != 0). busy = (cnt != 0).
  - RUN: cnt decrements every cycle.
  - On the edge where cnt goes 1 -> 0: HI = hi_n, LO = lo_n, state returns to IDLE.
- lock gates acceptance only. An operation already in RUN was issued by an older, committed instruction, so it completes and writes HI/LO regardless of lock.
- stall = hilo_use_D & (busy | (accept & op is mult/multu/div/divu)).
- HIO/LOO always show the committed HI/LO. Results in flight are never visible early.

## Timing
- Reset (rst_n low, asynchronous): HIO = 0, LOO = 0, busy = 0, stall = 0 combinationally from the inputs, cnt = 0, hi_n = lo_n = 0.
- Release of rst_n takes effect at the next clk edge. Reset during RUN aborts the operation with no HI/LO write.
- mult accepted at edge t:
  - busy is high in cycles t+1 .. t+MULT_CYCLES.
  - New HI/LO are visible from cycle t+MULT_CYCLES+1, the first cycle busy is low.
- div follows the same pattern with DIV_CYCLES.
- mthi/mtlo accepted at edge t: new value visible in cycle t+1. A following mfhi sees it one cycle later with no stall.
- stall is combinational from busy, start, op, lock and hilo_use_D. No registered delay.
- Back-to-back: a second mult in D stalls until busy falls. It enters E in the first non-busy cycle and is accepted at that cycle's edge. There is no bubble beyond the latency.

## Test plan
- Reset: hold rst_n low mid-cycle with start=1 -> HIO = LOO = 0, busy = 0 immediately. Release, then issue nothing -> all outputs stay 0.
- mult A = 32'hFFFF_FFFE (-2), B = 3, accepted at edge 0 -> busy high for cycles 1-5. HI = 32'hFFFF_FFFF, LO = 32'hFFFF_FFFA from cycle 6. multu on the same operands -> HI = 2, LO = 32'hFFFF_FFFA.
- div A = -7, B = 2 -> after 10 busy cycles, LO = 32'hFFFF_FFFD (-3), HI = 32'hFFFF_FFFF (-1).
  - divu A = 7, B = 0 -> LO = 32'hFFFF_FFFF, HI = 7.
  - div 32'h8000_0000 / -1 -> LO = 32'h8000_0000, HI = 0.
- lock: start=1, op=mult, lock=1 -> busy stays 0, HI/LO unchanged, stall = 0.
  - Repeat with an op already in RUN and lock pulsed -> the op completes and HI/LO update on schedule.
- Stall: div accepted while hilo_use_D=1 (mflo in D) -> stall high from the accepting cycle through the last busy cycle. mflo then reads the new LO.
  - mtlo A = 32'h1234_5678 with hilo_use_D=1 -> no stall, LOO = 32'h1234_5678 next cycle.
- start asserted while busy (forced, protocol violation) -> ignored: cnt keeps counting and the first result commits unchanged.
